// File: rtl/program_loader_if.sv
// Host-to-loader word stream: valid/ready handshake carrying instruction words
// and an end-of-program marker.
interface program_loader_if #(
    parameter int unsigned N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_word;
    logic         in_last;

    modport master (output in_valid, output in_word, output in_last, input in_ready);
    modport slave  (input in_valid, input in_word, input in_last, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Streams host instruction words into the instruction cache, then releases the
// CPU by pulsing loadPC with the session's entry PC.
module program_loader #(
    parameter int unsigned N      = 32,
    parameter int unsigned ADDR_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [29:0]         entry_pc,
    program_loader_if.slave     host,
    output logic                prog,
    output logic [ADDR_W-1:0]   blockAddr,
    output logic [N-1:0]        Iword,
    output logic                loadPC,
    output logic [29:0]         initPC,
    output logic [ADDR_W:0]     word_count,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BOOT, S_RUN, S_ERR} state_e;

    localparam logic [ADDR_W:0] WC_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] WC_LAST = {1'b0, {ADDR_W{1'b1}}};

    state_e              state_q, state_d;
    logic [29:0]         entry_q, entry_d;
    logic                prog_q, prog_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [N-1:0]        iword_q, iword_d;
    logic                loadpc_q, loadpc_d;
    logic [29:0]         initpc_q, initpc_d;
    logic [ADDR_W:0]     wc_q, wc_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                hs;

    assign host.in_ready = (state_q == S_LOAD);
    assign hs            = host.in_valid && (state_q == S_LOAD);

    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        prog_d   = 1'b0;
        addr_d   = addr_q;
        iword_d  = iword_q;
        loadpc_d = 1'b0;
        initpc_d = initpc_q;
        wc_d     = wc_q;
        done_d   = done_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    entry_d = entry_pc;
                    wc_d    = '0;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    prog_d  = 1'b1;
                    addr_d  = wc_q[ADDR_W-1:0];
                    iword_d = host.in_word;
                    if (wc_q != WC_FULL) wc_d = wc_q + 1'b1;
                    if (host.in_last)          state_d = S_BOOT;
                    else if (wc_q == WC_LAST)  state_d = S_ERR;
                end
            end
            // BOOT follows the final write, so loadPC lands the cycle after the last prog pulse.
            S_BOOT: begin
                loadpc_d = 1'b1;
                initpc_d = entry_q;
                state_d  = S_RUN;
            end
            S_RUN: begin
                done_d = 1'b1;
                if (start) begin
                    done_d  = 1'b0;
                    entry_d = entry_pc;
                    wc_d    = '0;
                    state_d = S_LOAD;
                end
            end
            S_ERR: begin
                err_d = 1'b1;
                if (start) begin
                    err_d   = 1'b0;
                    entry_d = entry_pc;
                    wc_d    = '0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            entry_q  <= '0;
            prog_q   <= 1'b0;
            addr_q   <= '0;
            iword_q  <= '0;
            loadpc_q <= 1'b0;
            initpc_q <= '0;
            wc_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            prog_q   <= prog_d;
            addr_q   <= addr_d;
            iword_q  <= iword_d;
            loadpc_q <= loadpc_d;
            initpc_q <= initpc_d;
            wc_q     <= wc_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign prog       = prog_q;
    assign blockAddr  = addr_q;
    assign Iword      = iword_q;
    assign loadPC     = loadpc_q;
    assign initPC     = initpc_q;
    assign word_count = wc_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: an event-schedule model predicts every
// output each cycle, plus literal checks at key points of each scenario.
module tb_program_loader;
    localparam int N  = 32;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [29:0]   entry_pc = '0;
    logic          prog, loadPC, done, err;
    logic [AW-1:0] blockAddr;
    logic [N-1:0]  Iword;
    logic [29:0]   initPC;
    logic [AW:0]   word_count;

    int checks   = 0;
    int failures = 0;

    program_loader_if #(.N(N)) host_if ();

    program_loader #(.N(N), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .entry_pc   (entry_pc),
        .host       (host_if),
        .prog       (prog),
        .blockAddr  (blockAddr),
        .Iword      (Iword),
        .loadPC     (loadPC),
        .initPC     (initPC),
        .word_count (word_count),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Model: a session accepts words while active; the last word schedules
    // loadPC one edge later and done two edges later; overflow schedules err.
    bit          m_valid = 0;
    bit          m_active = 0;
    bit          m_can_start = 0;
    int          m_count = 0;
    logic [29:0] m_pc = '0;
    int          boot_cd = 0, done_cd = 0, err_cd = 0;
    bit          e_prog = 0, e_loadpc = 0, e_done = 0, e_err = 0;
    int          e_addr = 0;
    logic [N-1:0] e_word = '0;
    logic [29:0]  e_initpc = '0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_valid = 1; m_active = 0; m_can_start = 1; m_count = 0; m_pc = '0;
            boot_cd = 0; done_cd = 0; err_cd = 0;
            e_prog = 0; e_loadpc = 0; e_done = 0; e_err = 0;
            e_addr = 0; e_word = '0; e_initpc = '0;
        end else if (m_valid) begin
            e_prog = 0;
            e_loadpc = 0;
            if (boot_cd > 0) begin
                boot_cd--;
                if (boot_cd == 0) begin e_loadpc = 1; e_initpc = m_pc; end
            end
            if (done_cd > 0) begin
                done_cd--;
                if (done_cd == 0) begin e_done = 1; m_can_start = 1; end
            end
            if (err_cd > 0) begin
                err_cd--;
                if (err_cd == 0) begin e_err = 1; m_can_start = 1; end
            end
            if (start && m_can_start) begin
                m_can_start = 0; m_active = 1; m_count = 0; m_pc = entry_pc;
                e_done = 0; e_err = 0;
            end else if (m_active && host_if.in_valid) begin
                e_prog = 1;
                e_addr = m_count;
                e_word = host_if.in_word;
                if (m_count < (1 << AW)) m_count++;
                if (host_if.in_last) begin
                    m_active = 0; boot_cd = 1; done_cd = 2;
                end else if (m_count == (1 << AW)) begin
                    m_active = 0; err_cd = 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("in_ready",   64'(host_if.in_ready), 64'(m_active));
            chk("prog",       64'(prog),       64'(e_prog));
            chk("blockAddr",  64'(blockAddr),  64'(e_addr));
            chk("Iword",      64'(Iword),      64'(e_word));
            chk("loadPC",     64'(loadPC),     64'(e_loadpc));
            chk("initPC",     64'(initPC),     64'(e_initpc));
            chk("word_count", 64'(word_count), 64'(m_count));
            chk("done",       64'(done),       64'(e_done));
            chk("err",        64'(err),        64'(e_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [29:0] pc);
        start = 1'b1; entry_pc = pc;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [N-1:0] w, input logic last);
        host_if.in_valid = 1'b1; host_if.in_word = w; host_if.in_last = last;
        tick();
        host_if.in_valid = 1'b0; host_if.in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        host_if.in_valid = 1'b0;
        host_if.in_word  = '0;
        host_if.in_last  = 1'b0;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("lit_reset_prog", 64'(prog), 64'd0);
        chk("lit_reset_wc",   64'(word_count), 64'd0);
        chk("lit_reset_rdy",  64'(host_if.in_ready), 64'd0);

        // Five back-to-back words from entry 0
        pulse_start(30'h0);
        for (int i = 0; i < 5; i++) send(32'h100 + 32'(i), i == 4);
        @(negedge clk);
        chk("lit_b2b_addr4", 64'(blockAddr), 64'd4);
        chk("lit_b2b_word4", 64'(Iword), 64'h104);
        tick();
        @(negedge clk);
        chk("lit_b2b_loadpc", 64'(loadPC), 64'd1);
        chk("lit_b2b_prog0",  64'(prog), 64'd0);
        tick();
        @(negedge clk);
        chk("lit_b2b_done", 64'(done), 64'd1);
        chk("lit_b2b_wc",   64'(word_count), 64'd5);
        idle(2);

        // Three words with two-cycle gaps
        pulse_start(30'h20);
        for (int i = 0; i < 3; i++) begin
            idle(2);
            send(32'hA0 + 32'(i), i == 2);
        end
        @(negedge clk);
        chk("lit_gap_addr2", 64'(blockAddr), 64'd2);
        idle(4);

        // Reload from RUN with entry 0x10
        pulse_start(30'h10);
        send(32'hBEEF0000, 1'b0);
        @(negedge clk);
        chk("lit_reload_addr0", 64'(blockAddr), 64'd0);
        send(32'hBEEF0001, 1'b1);
        tick();
        @(negedge clk);
        chk("lit_reload_initpc", 64'(initPC), 64'h10);
        tick();
        @(negedge clk);
        chk("lit_reload_wc", 64'(word_count), 64'd2);
        idle(2);

        // start pulses inside LOAD are ignored
        pulse_start(30'h30);
        send(32'hC0, 1'b0);
        pulse_start(30'h99);
        start = 1'b1; entry_pc = 30'h77;
        send(32'hC1, 1'b0);
        start = 1'b0;
        send(32'hC2, 1'b1);
        idle(3);
        @(negedge clk);
        chk("lit_ign_wc",     64'(word_count), 64'd3);
        chk("lit_ign_initpc", 64'(initPC), 64'h30);

        // Reset mid-load with a word offered in the reset cycle
        pulse_start(30'h40);
        for (int i = 0; i < 3; i++) send(32'hD0 + 32'(i), 1'b0);
        rst = 1'b1; host_if.in_valid = 1'b1; host_if.in_word = 32'hDEAD;
        tick();
        rst = 1'b0; host_if.in_valid = 1'b0;
        @(negedge clk);
        chk("lit_rst_prog",  64'(prog), 64'd0);
        chk("lit_rst_addr",  64'(blockAddr), 64'd0);
        chk("lit_rst_word",  64'(Iword), 64'd0);
        chk("lit_rst_wc",    64'(word_count), 64'd0);
        chk("lit_rst_initpc",64'(initPC), 64'd0);
        pulse_start(30'h44);
        send(32'hE0, 1'b1);
        @(negedge clk);
        chk("lit_rst_reload_addr", 64'(blockAddr), 64'd0);
        idle(3);

        // Overflow: 128 words without in_last
        pulse_start(30'h50);
        for (int i = 0; i < 128; i++) send(32'(i) * 3 + 7, 1'b0);
        @(negedge clk);
        chk("lit_ovf_addr", 64'(blockAddr), 64'd127);
        chk("lit_ovf_word", 64'(Iword), 64'd388);
        chk("lit_ovf_wc",   64'(word_count), 64'd128);
        tick();
        @(negedge clk);
        chk("lit_ovf_err", 64'(err), 64'd1);
        send(32'hFFFF, 1'b1);
        idle(2);
        pulse_start(30'h60);
        @(negedge clk);
        chk("lit_ovf_clr", 64'(err), 64'd0);
        send(32'hF0, 1'b1);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
